counter_cmd_sequencer: RTL and testbench
========================================

// Module: counter_cmd_sequencer
// PURPOSE
//  Upstream driver for the three-bit up-counter. Accepts LOAD/INC commands on a
//  valid/ready interface, buffers them, and issues at most one ld or inc pulse
//  per issue slot to the counter's ld/inc/data_in inputs.
//  Keeps a shadow copy of the counter value and drops any INC that would take
//  the count past its maximum, so the counter's overflow check never fires.
// PARAMETERS
//  WIDTH       3  counter/data width; MAX = 2**WIDTH-1
//  DEPTH       4  command FIFO entries; power of two, >=2
//  GAP_CYCLES  0  idle cycles inserted after each issued or dropped command (0..15)
// PORTS
//  clk           in   1      rising-edge clock
//  rst           in   1      synchronous reset, active-high; shared with the counter
//  cmd_valid     in   1      command present
//  cmd_ready     out  1      FIFO can accept; = !full
//  cmd_op        in   1      0 = INC, 1 = LOAD
//  cmd_data      in   WIDTH  load value; ignored for INC
//  ld            out  1      to counter ld, registered
//  inc           out  1      to counter inc, registered
//  data_in       out  WIDTH  to counter data_in, registered
//  shadow_count  out  WIDTH  expected counter value after the last issued pulse
//  drop          out  1      one-cycle pulse: INC discarded at MAX
//  busy          out  1      FIFO non-empty or state != IDLE
// BEHAVIOUR
//  - Reset (sync, rst=1 at a clock edge): FIFO emptied; state IDLE; ld=inc=drop=0;
//    data_in=0; shadow_count=0; cmd_ready=1 from the cycle after the edge.
//    rst mid-operation discards all queued commands. Nothing is issued while rst=1.
//  - Accept: push when cmd_valid & cmd_ready at the edge. cmd_ready depends only on
//    full: it stays 0 when full even if a pop happens in the same cycle.
//    Push and pop in the same cycle are both honoured when not full.
//  - FSM states: IDLE, ISSUE, GAP.
//    IDLE : FIFO non-empty -> ISSUE.
//    ISSUE: pop the head at the edge and decode it:
//           LOAD -> ld=1, data_in=cmd_data, shadow<=cmd_data.
//           INC, shadow<MAX -> inc=1, shadow<=shadow+1.
//           INC, shadow==MAX -> ld=inc=0, drop=1, shadow unchanged.
//           Next state: GAP if GAP_CYCLES>0; else ISSUE if more entries remain,
//           else IDLE.
//    GAP  : counts GAP_CYCLES cycles with no output pulses, then goes to ISSUE if
//           the FIFO is non-empty, else IDLE.
//  - ld/inc/drop are single-cycle pulses, mutually exclusive, never both set.
//    data_in holds its last value when ld=0.
//  - Latency, empty FIFO, GAP_CYCLES=0: a command accepted at edge k produces its
//    ld/inc/drop pulse in the cycle after edge k+2 (k+1: IDLE->ISSUE; k+2: pop).
//  - Throughput with GAP_CYCLES=0: one command per cycle.
//  - Shadow arithmetic is WIDTH bits and never wraps, because INC at MAX is dropped.
//    A LOAD to MAX is legal.
//  - After the pulse, shadow_count equals the counter's data_out one cycle later,
//    given the counter resets to 0 on the same rst.
// CONFIGURATION
//  CMD_SEQ_STATS_EN defined: adds output ports issued_cnt[15:0] and dropped_cnt[15:0].
//    issued_cnt increments on each ld/inc pulse; dropped_cnt on each drop pulse.
//    Both saturate at 16'hFFFF and are cleared by rst.
//  CMD_SEQ_STATS_EN undefined: these ports and their logic are absent; all other
//    behaviour is identical.
// TESTING
//  1 Reset: hold rst 2 cycles mid-stream with 3 queued -> ld=inc=0, shadow=0,
//    busy=0, cmd_ready=1; queued commands are never issued.
//  2 LOAD 5 then INC x3 back-to-back (GAP=0) -> ld with data_in=5, inc, inc, then
//    drop; shadow ends at 7; counter never exceeds 7.
//  3 Fill with 4 INCs while issue is stalled -> cmd_ready=0 after the 4th accept,
//    and returns to 1 the cycle after the first pop.
//  4 GAP_CYCLES=2, 3 INCs from shadow 0 -> inc pulses 3 cycles apart; shadow=3.
//  5 LOAD 7, INC, LOAD 0, INC -> ld(7), drop, ld(0), inc; shadow=1; never ld&inc.
//  6 CMD_SEQ_STATS_EN defined, scenario 2 -> issued_cnt=3, dropped_cnt=1.

Source files
------------

// File: rtl/counter_cmd_sequencer.sv
// counter_cmd_sequencer: queues LOAD/INC commands and issues ld/inc pulses, dropping INCs at MAX; CMD_SEQ_STATS_EN adds issued/dropped counters
module counter_cmd_sequencer #(
  parameter int WIDTH      = 3,
  parameter int DEPTH      = 4,
  parameter int GAP_CYCLES = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  output logic             ld,
  output logic             inc,
  output logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] shadow_count,
  output logic             drop,
  output logic             busy
`ifdef CMD_SEQ_STATS_EN
  ,
  output logic [15:0]      issued_cnt,
  output logic [15:0]      dropped_cnt
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [WIDTH-1:0] MAX = '1;
  typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;
  state_t state, state_nx;
  logic [WIDTH:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic [3:0] gap_cnt;
  logic push, pop, empty, full, head_op;
  logic [WIDTH-1:0] head_data;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign cmd_ready = !full;
  assign push = cmd_valid && cmd_ready;
  assign {head_op, head_data} = mem[rd_ptr];
  assign busy = !empty || state != IDLE;
  always_comb begin
    state_nx = state;
    pop = 1'b0;
    unique case (state)
      IDLE:  state_nx = empty ? IDLE : ISSUE;
      ISSUE: begin
        pop = !empty;
        state_nx = GAP_CYCLES > 0 ? GAP : (count > (AW+1)'(1) || push) ? ISSUE : IDLE;
      end
      GAP:     state_nx = gap_cnt != '0 ? GAP : empty ? IDLE : ISSUE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {cmd_op, cmd_data};
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      gap_cnt <= '0;
      ld <= 1'b0;
      inc <= 1'b0;
      drop <= 1'b0;
      data_in <= '0;
      shadow_count <= '0;
    end else begin
      ld <= 1'b0;
      inc <= 1'b0;
      drop <= 1'b0;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
      if (state == ISSUE) gap_cnt <= 4'(GAP_CYCLES - 1);
      else if (gap_cnt != '0) gap_cnt <= gap_cnt - 1'b1;
      if (pop && head_op) begin
        ld <= 1'b1;
        data_in <= head_data;
        shadow_count <= head_data;
      end else if (pop && shadow_count != MAX) begin
        inc <= 1'b1;
        shadow_count <= shadow_count + 1'b1;
      end else if (pop) drop <= 1'b1;
    end
  end
`ifdef CMD_SEQ_STATS_EN
  always_ff @(posedge clk)
    if (rst) begin
      issued_cnt <= '0;
      dropped_cnt <= '0;
    end else begin
      if ((ld || inc) && issued_cnt != '1) issued_cnt <= issued_cnt + 1'b1;
      if (drop && dropped_cnt != '1) dropped_cnt <= dropped_cnt + 1'b1;
    end
`endif
endmodule

// File: tb/tb_counter_cmd_sequencer.sv
// tb_counter_cmd_sequencer: scoreboard bench with a command-level reference model and a counter model
module tb_counter_cmd_sequencer;
  localparam logic [2:0] MAX = 3'd7;
  typedef struct packed {logic [2:0] kind; logic [2:0] d; logic [2:0] sh;} exp_t;
  logic clk = 0, rst, cmd_valid, cmd_op, cmd_ready, ld, inc, drop, busy;
  logic [2:0] cmd_data, data_in, shadow_count;
  logic g_valid, g_op, g_ready, g_ld, g_inc, g_drop, g_busy;
  logic [2:0] g_data, g_din, g_shadow;
`ifdef CMD_SEQ_STATS_EN
  logic [15:0] issued_cnt, dropped_cnt, g_iss, g_drp;
`endif
  exp_t exp_q[$];
  exp_t mon_e, acc_e;
  logic [2:0] m_sh, ctr;
  int m_iss, m_drp, checks = 0, errs = 0;
  bit mon_en = 0;
  always #5 clk = ~clk;
  counter_cmd_sequencer #(.WIDTH(3), .DEPTH(4), .GAP_CYCLES(0)) u0 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_data(cmd_data), .ld(ld), .inc(inc), .data_in(data_in), .shadow_count(shadow_count),
    .drop(drop), .busy(busy)
`ifdef CMD_SEQ_STATS_EN
    , .issued_cnt(issued_cnt), .dropped_cnt(dropped_cnt)
`endif
  );
  counter_cmd_sequencer #(.WIDTH(3), .DEPTH(4), .GAP_CYCLES(2)) u_gap (
    .clk(clk), .rst(rst), .cmd_valid(g_valid), .cmd_ready(g_ready), .cmd_op(g_op),
    .cmd_data(g_data), .ld(g_ld), .inc(g_inc), .data_in(g_din), .shadow_count(g_shadow),
    .drop(g_drop), .busy(g_busy)
`ifdef CMD_SEQ_STATS_EN
    , .issued_cnt(g_iss), .dropped_cnt(g_drp)
`endif
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  always @(posedge clk) begin
    if (rst) begin
      exp_q.delete();
      m_sh = 0;
      m_iss = 0;
      m_drp = 0;
      ctr <= 0;
    end else begin
      if (cmd_valid && cmd_ready) begin
        if (cmd_op) begin
          m_sh = cmd_data;
          acc_e = '{3'b100, cmd_data, cmd_data};
        end else if (m_sh < MAX) begin
          m_sh = m_sh + 1;
          acc_e = '{3'b010, 3'd0, m_sh};
        end else acc_e = '{3'b001, 3'd0, m_sh};
        exp_q.push_back(acc_e);
      end
      if (mon_en && ld) ctr <= data_in;
      else if (mon_en && inc) begin
        chk("counter_overflow", {29'd0, ctr}, {29'd0, ctr == MAX ? 3'd0 : ctr});
        ctr <= ctr + 1;
      end
    end
  end
  always @(negedge clk)
    if (mon_en) begin
      if (ld || inc || drop) begin
        if (exp_q.size() == 0) begin
          checks++;
          errs++;
          $display("FAIL unexpected_pulse: got ld=%b inc=%b drop=%b, required none", ld, inc, drop);
        end else begin
          mon_e = exp_q.pop_front();
          chk("pulse_kind", {29'd0, ld, inc, drop}, {29'd0, mon_e.kind});
          if (mon_e.kind[2]) chk("data_in", {29'd0, data_in}, {29'd0, mon_e.d});
          chk("shadow_after_pulse", {29'd0, shadow_count}, {29'd0, mon_e.sh});
          if (mon_e.kind[0]) m_drp++;
          else m_iss++;
        end
      end
      if (!ld && !inc) chk("shadow_vs_counter", {29'd0, shadow_count}, {29'd0, ctr});
    end
  task automatic send(input logic op, input logic [2:0] d);
    cmd_valid = 1;
    cmd_op = op;
    cmd_data = d;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        @(posedge clk);
        #1 cmd_valid = 0;
        return;
      end
    end
    checks++;
    errs++;
    $display("FAIL send_timeout: got cmd_ready=0 for 50 cycles, required 1");
    cmd_valid = 0;
  endtask
  task automatic wait_idle();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy && exp_q.size() == 0) begin
        repeat (2) @(negedge clk);
        return;
      end
    end
    checks++;
    errs++;
    $display("FAIL idle_timeout: got busy=%b queued=%0d, required idle", busy, exp_q.size());
  endtask
  initial begin
    int times[$];
    int sent;
    bit saw_full, prev_rdy, acc;
    rst = 1;
    cmd_valid = 0;
    cmd_op = 0;
    cmd_data = 0;
    g_valid = 0;
    g_op = 0;
    g_data = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    mon_en = 1;
    @(negedge clk);
    chk("rst_ld", {31'd0, ld}, 0);
    chk("rst_inc", {31'd0, inc}, 0);
    chk("rst_drop", {31'd0, drop}, 0);
    chk("rst_data_in", {29'd0, data_in}, 0);
    chk("rst_shadow", {29'd0, shadow_count}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_ready", {31'd0, cmd_ready}, 1);
    @(posedge clk);
    #1;
    send(1, 5);
    repeat (3) send(0, 0);
    wait_idle();
    chk("s2_shadow", {29'd0, shadow_count}, 7);
`ifdef CMD_SEQ_STATS_EN
    chk("s2_issued_cnt", {16'd0, issued_cnt}, 3);
    chk("s2_dropped_cnt", {16'd0, dropped_cnt}, 1);
`endif
    @(posedge clk);
    #1;
    send(1, 7);
    send(0, 0);
    send(1, 0);
    send(0, 0);
    wait_idle();
    chk("s5_shadow", {29'd0, shadow_count}, 1);
    @(posedge clk);
    #1 g_valid = 1;
    sent = 0;
    saw_full = 0;
    prev_rdy = 1;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (g_inc) times.push_back(c);
      if (g_ld || g_drop) chk("gap_no_ld_drop", {30'd0, g_ld, g_drop}, 0);
      if (g_inc && !prev_rdy) chk("gap_ready_after_pop", {31'd0, g_ready}, 1);
      if (!g_ready) saw_full = 1;
      prev_rdy = g_ready;
      acc = g_valid && g_ready;
      @(posedge clk);
      #1;
      if (acc && ++sent == 5) g_valid = 0;
    end
    chk("gap_saw_full", {31'd0, saw_full}, 1);
    chk("gap_pulse_count", times.size(), 5);
    for (int i = 1; i < times.size(); i++) chk("gap_spacing", times[i] - times[i-1], 3);
    chk("gap_shadow", {29'd0, g_shadow}, 5);
    repeat (3) send(0, 0);
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("midrst_ld_inc", {30'd0, ld, inc}, 0);
    chk("midrst_shadow", {29'd0, shadow_count}, 0);
    chk("midrst_busy", {31'd0, busy}, 0);
    chk("midrst_ready", {31'd0, cmd_ready}, 1);
    repeat (10) @(negedge clk);
    chk("midrst_still_idle", {31'd0, busy}, 0);
    @(posedge clk);
    #1;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      acc = cmd_valid && cmd_ready && !rst;
      @(posedge clk);
      #1 rst = $urandom_range(0, 99) == 0;
      if (acc || !cmd_valid) begin
        cmd_valid = $urandom_range(0, 2) != 0;
        cmd_op = $urandom_range(0, 3) == 0;
        cmd_data = 3'($urandom);
      end
    end
    cmd_valid = 0;
    rst = 0;
    wait_idle();
    chk("drain_queue_empty", exp_q.size(), 0);
    chk("final_shadow", {29'd0, shadow_count}, {29'd0, m_sh});
`ifdef CMD_SEQ_STATS_EN
    chk("final_issued_cnt", {16'd0, issued_cnt}, m_iss);
    chk("final_dropped_cnt", {16'd0, dropped_cnt}, m_drp);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errs);
    $finish;
  end
endmodule
